gpio_input_debouncer: RTL and testbench



---
 rtl/gpio_input_debouncer.sv | 92 +++++++++
 tb/tb_gpio_input_debouncer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_debouncer.sv
// Conditions asynchronous board switch/button inputs: synchronise, debounce on a shared
// sample tick, and emit clean levels plus single-cycle rise/fall strobes.
module gpio_input_debouncer #(
  parameter int unsigned NCH          = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter logic        RST_VAL      = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] din_i,
  output logic [NCH-1:0] db_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic           change_o,
  output logic           tick_o
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SC_LAST  = SW'(STABLE_TICKS - 1);

  logic [NCH-1:0] sync_q [SYNC_STAGES];
  logic [NCH-1:0] s;
  logic [CW-1:0]  cnt_q;
  logic [SW-1:0]  sc_q [NCH];
  logic [SW-1:0]  sc_d [NCH];
  logic [NCH-1:0] db_d;
  logic [NCH-1:0] rise_d;
  logic [NCH-1:0] fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {NCH{RST_VAL}};
    end else begin
      sync_q[0] <= din_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Tick is decoded from the counter register, so it is glitch-free and one cycle wide.
  assign tick_o = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + CW'(1);
  end

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    db_d   = db_o;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sc_d[i] = sc_q[i];
      if (s[i] == db_o[i]) begin
        sc_d[i] = '0;
      end else if (tick_o) begin
        if (sc_q[i] >= SC_LAST) begin
          db_d[i]   = s[i];
          sc_d[i]   = '0;
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          sc_d[i] = sc_q[i] + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_o     <= {NCH{RST_VAL}};
      rise_o   <= '0;
      fall_o   <= '0;
      change_o <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) sc_q[i] <= '0;
    end else begin
      db_o     <= db_d;
      rise_o   <= rise_d;
      fall_o   <= fall_d;
      change_o <= |(rise_d | fall_d);
      for (int unsigned i = 0; i < NCH; i++) sc_q[i] <= sc_d[i];
    end
  end

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// Scoreboard bench for gpio_input_debouncer: expected strobes are queued when stimulus is
// driven and matched against strobes captured by a monitor.
module tb_gpio_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_i;
  logic [7:0] db_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic       change_o;
  logic       tick_o;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] db;
    logic       chg;
  } obs_t;

  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] db;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  gpio_input_debouncer #(
    .NCH         (8),
    .SYNC_STAGES (2),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .RST_VAL     (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din_i   (din_i),
    .db_o    (db_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .change_o(change_o),
    .tick_o  (tick_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((rise_o | fall_o) != 8'h00 || change_o !== 1'b0)
      obs_q.push_back('{cyc, rise_o, fall_o, db_o, change_o});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    din_i = 8'hFF;
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if ({db_o, rise_o, fall_o, change_o, tick_o} !== 26'h0) begin
        miscompares++;
        $display("FAIL reset_state: db=%h rise=%h fall=%h chg=%b tick=%b, required all zero",
                 db_o, rise_o, fall_o, change_o, tick_o);
      end
    end
    din_i = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    cycles(3);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_pulses: %0d strobes seen, required 0", obs_q.size());
    end
  endtask

  task automatic test_clean_rise;
    int c0;
    int last;
    last = -1;
    @(negedge clk);
    din_i[0] = 1'b1;
    c0 = cyc;
    exp_q.push_back('{c0 + 11, c0 + 14, 8'h01, 8'h00, 8'h01});
    repeat (20) begin
      @(negedge clk);
      if (tick_o) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last != 4) begin
            miscompares++;
            $display("FAIL tick_period: got %0d cycles, required 4", cyc - last);
          end
        end
        last = cyc;
      end
    end
    vectors++;
    if (last < 0) begin
      miscompares++;
      $display("FAIL tick_seen: no tick in 20 cycles, required periodic tick");
    end
    vectors++;
    if (db_o !== 8'h01) begin
      miscompares++;
      $display("FAIL clean_rise_db: db=%h, required 01", db_o);
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL clean_rise_pulse: missing strobe, required rise=%h fall=%h", e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc < e.lo || o.cyc > e.hi || o.rise !== e.rise || o.fall !== e.fall ||
            o.db !== e.db || o.chg !== 1'b1) begin
          miscompares++;
          $display("FAIL clean_rise_pulse: cyc=%0d rise=%h fall=%h db=%h chg=%b, required cyc %0d..%0d rise=%h fall=%h db=%h chg=1",
                   o.cyc, o.rise, o.fall, o.db, o.chg, e.lo, e.hi, e.rise, e.fall, e.db);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL clean_rise_extra: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_bounce;
    int c0;
    c0 = 0;
    for (int k = 0; k < 13; k++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (j == 0) begin
          din_i[1] = (k % 2 == 0);
          if (k == 12) c0 = cyc;
        end
        vectors++;
        if (db_o !== 8'h01 || obs_q.size() != 0) begin
          miscompares++;
          $display("FAIL bounce_quiet: db=%h strobes=%0d, required db=01 strobes=0",
                   db_o, obs_q.size());
          obs_q.delete();
        end
      end
    end
    exp_q.push_back('{c0 + 11, c0 + 14, 8'h02, 8'h00, 8'h03});
    cycles(14);
    vectors++;
    if (db_o !== 8'h03) begin
      miscompares++;
      $display("FAIL bounce_settle_db: db=%h, required 03", db_o);
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL bounce_pulse: missing strobe, required rise=%h fall=%h", e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc < e.lo || o.cyc > e.hi || o.rise !== e.rise || o.fall !== e.fall ||
            o.db !== e.db || o.chg !== 1'b1) begin
          miscompares++;
          $display("FAIL bounce_pulse: cyc=%0d rise=%h fall=%h db=%h chg=%b, required cyc %0d..%0d rise=%h fall=%h db=%h chg=1",
                   o.cyc, o.rise, o.fall, o.db, o.chg, e.lo, e.hi, e.rise, e.fall, e.db);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL bounce_extra: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_fall_simultaneous;
    logic [7:0] pat  [3];
    logic [7:0] rexp [3];
    logic [7:0] fexp [3];
    pat  = '{8'h0F, 8'hF0, 8'h00};
    rexp = '{8'h0C, 8'hF0, 8'h00};
    fexp = '{8'h00, 8'h0F, 8'hF0};
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      din_i = pat[p];
      exp_q.push_back('{cyc + 11, cyc + 14, rexp[p], fexp[p], pat[p]});
      cycles(16);
      vectors++;
      if (db_o !== pat[p]) begin
        miscompares++;
        $display("FAIL simul_db_%0d: db=%h, required %h", p, db_o, pat[p]);
      end
    end
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL simul_pulse: missing strobe, required rise=%h fall=%h", e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc < e.lo || o.cyc > e.hi || o.rise !== e.rise || o.fall !== e.fall ||
            o.db !== e.db || o.chg !== 1'b1) begin
          miscompares++;
          $display("FAIL simul_pulse: cyc=%0d rise=%h fall=%h db=%h chg=%b, required cyc %0d..%0d rise=%h fall=%h db=%h chg=1",
                   o.cyc, o.rise, o.fall, o.db, o.chg, e.lo, e.hi, e.rise, e.fall, e.db);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL simul_extra: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_count;
    int c0;
    @(negedge clk);
    din_i[2] = 1'b1;
    cycles(9);
    rst      = 1'b1;
    din_i[2] = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(20);
    vectors++;
    if (db_o !== 8'h00 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_abort: db=%h strobes=%0d, required db=00 strobes=0", db_o, obs_q.size());
      obs_q.delete();
    end
    din_i[2] = 1'b1;
    cycles(9);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    c0  = cyc;
    // Prescaler and synchroniser both restart from release, so the commit edge is exact.
    exp_q.push_back('{c0 + 12, c0 + 12, 8'h04, 8'h00, 8'h04});
    cycles(16);
    vectors++;
    if (db_o !== 8'h04) begin
      miscompares++;
      $display("FAIL reset_restart_db: db=%h, required 04", db_o);
    end
    din_i[2] = 1'b0;
    exp_q.push_back('{cyc + 11, cyc + 14, 8'h00, 8'h04, 8'h00});
    cycles(16);
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL reset_restart_pulse: missing strobe, required rise=%h fall=%h", e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc < e.lo || o.cyc > e.hi || o.rise !== e.rise || o.fall !== e.fall ||
            o.db !== e.db || o.chg !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_restart_pulse: cyc=%0d rise=%h fall=%h db=%h chg=%b, required cyc %0d..%0d rise=%h fall=%h db=%h chg=1",
                   o.cyc, o.rise, o.fall, o.db, o.chg, e.lo, e.hi, e.rise, e.fall, e.db);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_restart_extra: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_sub_threshold;
    @(negedge clk);
    din_i[3] = 1'b1;
    cycles(6);
    din_i[3] = 1'b0;
    cycles(3);
    vectors++;
    if (db_o !== 8'h00 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL sub_threshold: db=%h strobes=%0d, required db=00 strobes=0", db_o, obs_q.size());
      obs_q.delete();
    end
    din_i[3] = 1'b1;
    exp_q.push_back('{cyc + 11, cyc + 14, 8'h08, 8'h00, 8'h08});
    cycles(16);
    vectors++;
    if (db_o !== 8'h08) begin
      miscompares++;
      $display("FAIL sub_threshold_db: db=%h, required 08", db_o);
    end
    din_i[3] = 1'b0;
    exp_q.push_back('{cyc + 11, cyc + 14, 8'h00, 8'h08, 8'h00});
    cycles(16);
    while (exp_q.size() > 0) begin
      exp_t e;
      obs_t o;
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("FAIL sub_threshold_pulse: missing strobe, required rise=%h fall=%h", e.rise, e.fall);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc < e.lo || o.cyc > e.hi || o.rise !== e.rise || o.fall !== e.fall ||
            o.db !== e.db || o.chg !== 1'b1) begin
          miscompares++;
          $display("FAIL sub_threshold_pulse: cyc=%0d rise=%h fall=%h db=%h chg=%b, required cyc %0d..%0d rise=%h fall=%h db=%h chg=1",
                   o.cyc, o.rise, o.fall, o.db, o.chg, e.lo, e.hi, e.rise, e.fall, e.db);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL sub_threshold_extra: %0d extra strobes, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_fall_simultaneous();
    test_reset_mid_count();
    test_sub_threshold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
